// File: rtl/sdram_port_sched_pkg.sv
// Shared definitions for the sdram port scheduler: FSM encoding and a
// width helper for counters and indices.
package sdram_port_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sdram_port_sched_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// returned as one-hot vector plus index.
module rr_pick #(
   parameter int PORTS = 2,
   parameter int IDX_W = 1
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [PORTS-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 1; i <= PORTS; i++) begin
         cand = IDX_W'((int'(last) + i) % PORTS);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_port_sched.sv
// Round-robin scheduler sharing the sdram_ctrl access interface between PORTS
// requesters; holds a grant per access stream with optional forced release.
module sdram_port_sched
   import sdram_port_sched_pkg::*;
#(
   parameter int PORTS     = 2,
   parameter int HOLD_MAX  = 16,
   parameter int ADR_WIDTH = 32
) (
   input  logic                       sdram_clk,
   input  logic                       sdram_rst_n,
   input  logic [PORTS-1:0]           req_i,
   input  logic [PORTS-1:0]           we_i,
   input  logic [PORTS*ADR_WIDTH-1:0] adr_i,
   input  logic [PORTS*16-1:0]        dat_i,
   input  logic [PORTS*2-1:0]         sel_i,
   output logic [PORTS-1:0]           gnt_o,
   output logic [PORTS-1:0]           ack_o,
   output logic [15:0]                dat_o,
   input  logic                       ctrl_idle_i,
   output logic                       ctrl_acc_o,
   output logic                       ctrl_we_o,
   output logic [ADR_WIDTH-1:0]       ctrl_adr_o,
   output logic [15:0]                ctrl_dat_o,
   output logic [1:0]                 ctrl_sel_o,
   input  logic                       ctrl_ack_i,
   input  logic [15:0]                ctrl_dat_i
);

   localparam int IDX_W = clog2_min1(PORTS);
   localparam int HC_W  = clog2_min1(HOLD_MAX + 1);
   localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);

   state_t           state, state_nxt;
   logic [PORTS-1:0] gnt_nxt;
   logic [IDX_W-1:0] last, last_nxt;
   logic [HC_W-1:0]  hold_cnt, hold_nxt;
   logic [PORTS-1:0] pick_gnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic             force_rel;
   logic             has_gnt;

   rr_pick #(.PORTS(PORTS), .IDX_W(IDX_W)) u_pick (
      .req   (req_i),
      .last  (last),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // 'last' doubles as the granted port index while a grant is held.
   assign force_rel = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM) && (|(req_i & ~gnt_o));

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_o;
      last_nxt  = last;
      hold_nxt  = hold_cnt;
      case (state)
         ST_IDLE: begin
            if (ctrl_idle_i && pick_valid) begin
               state_nxt = ST_BUSY;
               gnt_nxt   = pick_gnt;
               last_nxt  = pick_idx;
               hold_nxt  = '0;
            end
         end
         ST_BUSY: begin
            if (ctrl_ack_i && (hold_cnt != HOLD_LIM)) hold_nxt = hold_cnt + 1'b1;
            if (!req_i[last] || force_rel) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (ctrl_idle_i) begin
               state_nxt = ST_IDLE;
               gnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment; the reset is synchronous, so it sits inside the clocked branch.
   always_ff @(posedge sdram_clk) begin
      if (!sdram_rst_n) begin
         state    <= ST_IDLE;
         gnt_o    <= '0;
         last     <= IDX_W'(PORTS - 1);
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt_o    <= gnt_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   assign has_gnt = |gnt_o;

   always_comb begin
      ctrl_acc_o = (state == ST_BUSY) && req_i[last];
      ack_o      = gnt_o & {PORTS{ctrl_ack_i}};
      dat_o      = ctrl_dat_i;
      ctrl_we_o  = has_gnt & we_i[last];
      ctrl_adr_o = has_gnt ? adr_i[last*ADR_WIDTH +: ADR_WIDTH] : '0;
      ctrl_dat_o = has_gnt ? dat_i[last*16 +: 16] : '0;
      ctrl_sel_o = has_gnt ? sel_i[last*2 +: 2] : '0;
   end

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched (PORTS=2, HOLD_MAX=4): a vector table
// for the basic grant/drain flow plus hand sequences for multi-cycle cases.
module tb_sdram_port_sched;

   logic        sdram_clk;
   logic        sdram_rst_n;
   logic [1:0]  req_i;
   logic [1:0]  we_i;
   logic [63:0] adr_i;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic [1:0]  gnt_o;
   logic [1:0]  ack_o;
   logic [15:0] dat_o;
   logic        ctrl_idle_i;
   logic        ctrl_acc_o;
   logic        ctrl_we_o;
   logic [31:0] ctrl_adr_o;
   logic [15:0] ctrl_dat_o;
   logic [1:0]  ctrl_sel_o;
   logic        ctrl_ack_i;
   logic [15:0] ctrl_dat_i;

   int n_cmp = 0;
   int n_bad = 0;

   sdram_port_sched #(.PORTS(2), .HOLD_MAX(4), .ADR_WIDTH(32)) dut (
      .sdram_clk   (sdram_clk),
      .sdram_rst_n (sdram_rst_n),
      .req_i       (req_i),
      .we_i        (we_i),
      .adr_i       (adr_i),
      .dat_i       (dat_i),
      .sel_i       (sel_i),
      .gnt_o       (gnt_o),
      .ack_o       (ack_o),
      .dat_o       (dat_o),
      .ctrl_idle_i (ctrl_idle_i),
      .ctrl_acc_o  (ctrl_acc_o),
      .ctrl_we_o   (ctrl_we_o),
      .ctrl_adr_o  (ctrl_adr_o),
      .ctrl_dat_o  (ctrl_dat_o),
      .ctrl_sel_o  (ctrl_sel_o),
      .ctrl_ack_i  (ctrl_ack_i),
      .ctrl_dat_i  (ctrl_dat_i)
   );

   initial sdram_clk = 1'b0;
   always #5 sdram_clk = ~sdram_clk;

   typedef struct {
      logic [1:0]  req;
      logic        idle;
      logic        ack;
      logic [1:0]  x_gnt;
      logic        x_acc;
      logic [1:0]  x_ack;
      logic        x_we;
      logic [31:0] x_adr;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] r, input logic i, input logic a);
      req_i       = r;
      ctrl_idle_i = i;
      ctrl_ack_i  = a;
   endtask

   task automatic settle();
      @(negedge sdram_clk);
   endtask

   task automatic step();
      @(posedge sdram_clk);
      #1;
   endtask

   task automatic idle_out(input string tag);
      drive(2'b00, 1'b1, 1'b0);
      step();
      step();
      step();
      settle();
      check({tag, " back to idle gnt"}, 32'(gnt_o), 32'h0);
      step();
   endtask

   initial begin
      // port0: read at 0x40; port1: write 0xBEEF at 0x100, both bytes
      we_i        = 2'b10;
      adr_i       = {32'h0000_0100, 32'h0000_0040};
      dat_i       = {16'hBEEF, 16'h1234};
      sel_i       = {2'b11, 2'b01};
      ctrl_dat_i  = 16'h5A5A;
      sdram_rst_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0);

      vecs[0]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0};
      vecs[1]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 32'h40};
      vecs[2]  = '{2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 32'h40};
      vecs[3]  = '{2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 32'h40};
      vecs[4]  = '{2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 32'h40};
      vecs[5]  = '{2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0};
      vecs[6]  = '{2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 32'h100};
      vecs[7]  = '{2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 32'h100};
      vecs[8]  = '{2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 32'h100};
      vecs[9]  = '{2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1, 32'h100};
      vecs[10] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0};

      // Reset state
      step();
      step();
      settle();
      check("reset gnt", 32'(gnt_o), 32'h0);
      check("reset acc", 32'(ctrl_acc_o), 32'h0);
      check("reset ack", 32'(ack_o), 32'h0);
      step();
      sdram_rst_n = 1'b1;

      // Basic round-robin flow: port0 first after reset, then port1
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].req, vecs[i].idle, vecs[i].ack);
         settle();
         check($sformatf("v%0d gnt", i), 32'(gnt_o), 32'(vecs[i].x_gnt));
         check($sformatf("v%0d acc", i), 32'(ctrl_acc_o), 32'(vecs[i].x_acc));
         check($sformatf("v%0d ack", i), 32'(ack_o), 32'(vecs[i].x_ack));
         check($sformatf("v%0d we", i), 32'(ctrl_we_o), 32'(vecs[i].x_we));
         check($sformatf("v%0d adr", i), ctrl_adr_o, vecs[i].x_adr);
         step();
      end

      // No grant while the controller is busy; grant one cycle after idle rises
      for (int i = 0; i < 10; i++) begin
         drive(2'b01, 1'b0, 1'b0);
         settle();
         check($sformatf("notidle c%0d gnt", i), 32'(gnt_o), 32'h0);
         step();
      end
      drive(2'b01, 1'b1, 1'b0);
      settle();
      check("idle rise same cycle gnt", 32'(gnt_o), 32'h0);
      step();
      settle();
      check("idle rise grant", 32'(gnt_o), 32'h1);
      check("idle rise acc", 32'(ctrl_acc_o), 32'h1);
      idle_out("t4");

      // Forced release after HOLD_MAX=4 acks while port1 waits
      drive(2'b01, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 1'b0, 1'b1);
         settle();
         check($sformatf("hold ack%0d acc", i), 32'(ctrl_acc_o), 32'h1);
         check($sformatf("hold ack%0d ack", i), 32'(ack_o), 32'h1);
         step();
      end
      drive(2'b11, 1'b0, 1'b0);
      step();
      settle();
      check("forced drain acc", 32'(ctrl_acc_o), 32'h0);
      check("forced drain gnt", 32'(gnt_o), 32'h1);
      step();
      drive(2'b11, 1'b1, 1'b0);
      settle();
      check("forced drain held gnt", 32'(gnt_o), 32'h1);
      step();
      settle();
      check("forced idle gap gnt", 32'(gnt_o), 32'h0);
      step();
      settle();
      check("forced switch gnt", 32'(gnt_o), 32'h2);
      check("forced switch acc", 32'(ctrl_acc_o), 32'h1);
      idle_out("t2");

      // Late acks after port0 drops its request go to ack_o[0] only
      drive(2'b01, 1'b1, 1'b0);
      step();
      drive(2'b01, 1'b0, 1'b0);
      settle();
      check("late busy gnt", 32'(gnt_o), 32'h1);
      step();
      drive(2'b10, 1'b0, 1'b0);
      settle();
      check("late drop acc", 32'(ctrl_acc_o), 32'h0);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(2'b10, 1'b0, 1'b1);
         settle();
         check($sformatf("late ack%0d", i), 32'(ack_o), 32'h1);
         check($sformatf("late ack%0d gnt", i), 32'(gnt_o), 32'h1);
         step();
      end
      idle_out("t3");

      // Round robin resumes at port1, then a one-edge reset mid-BUSY
      drive(2'b11, 1'b1, 1'b0);
      step();
      settle();
      check("rr port1 gnt", 32'(gnt_o), 32'h2);
      sdram_rst_n = 1'b0;
      drive(2'b11, 1'b1, 1'b1);
      step();
      sdram_rst_n = 1'b1;
      settle();
      check("midreset gnt", 32'(gnt_o), 32'h0);
      check("midreset acc", 32'(ctrl_acc_o), 32'h0);
      check("midreset ack", 32'(ack_o), 32'h0);
      step();
      drive(2'b11, 1'b1, 1'b0);
      settle();
      check("post reset port0 gnt", 32'(gnt_o), 32'h1);
      idle_out("t5");

      // Port1 write data routed to ctrl_*; all ctrl_* zero in IDLE
      drive(2'b10, 1'b0, 1'b0);
      settle();
      check("idle adr", ctrl_adr_o, 32'h0);
      check("idle dat", 32'(ctrl_dat_o), 32'h0);
      check("idle sel", 32'(ctrl_sel_o), 32'h0);
      check("idle we", 32'(ctrl_we_o), 32'h0);
      step();
      drive(2'b10, 1'b1, 1'b0);
      step();
      settle();
      check("wr gnt", 32'(gnt_o), 32'h2);
      check("wr adr", ctrl_adr_o, 32'h100);
      check("wr dat", 32'(ctrl_dat_o), 32'hBEEF);
      check("wr sel", 32'(ctrl_sel_o), 32'h3);
      check("wr we", 32'(ctrl_we_o), 32'h1);
      check("rd dat broadcast", 32'(dat_o), 32'h5A5A);
      idle_out("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
